// File: rtl/tt_um_jleugeri_ttt_event_fifo.sv
// Output-event buffer for the ticktocktokens core: a first-word-fall-through FIFO
// of {processor id, start/stop} entries with a sticky overflow flag and a saturating drop counter.
module tt_um_jleugeri_ttt_event_fifo #(
  parameter int PROC_ID_BITS  = 4,
  parameter int DEPTH         = 8,
  parameter int DROP_CNT_BITS = 8
) (
  input  logic                      clock_fast,
  input  logic                      reset,
  input  logic                      event_valid,
  input  logic [PROC_ID_BITS-1:0]   processor_id_in,
  input  logic [1:0]                token_startstop_in,
  input  logic                      pop,
  input  logic                      clear,
  output logic                      out_valid,
  output logic [PROC_ID_BITS-1:0]   processor_id_out,
  output logic [1:0]                token_startstop_out,
  output logic [$clog2(DEPTH):0]    count,
  output logic                      full,
  output logic                      overflow,
  output logic [DROP_CNT_BITS-1:0]  drop_count
);

  localparam int PTR_W   = $clog2(DEPTH);
  localparam int CNT_W   = PTR_W + 1;
  localparam int ENTRY_W = PROC_ID_BITS + 2;

  logic [ENTRY_W-1:0]       mem [DEPTH];
  logic [PTR_W-1:0]         rd_ptr;
  logic [PTR_W-1:0]         wr_ptr;
  logic [CNT_W-1:0]         cnt;
  logic                     ovf;
  logic [DROP_CNT_BITS-1:0] drops;

  logic push_req;
  logic pop_req;
  logic do_write;
  logic do_drop;
  logic [ENTRY_W-1:0] head;

  assign out_valid = (cnt != '0);
  assign full      = (cnt == CNT_W'(DEPTH));
  assign count     = cnt;
  assign overflow  = ovf;
  assign drop_count = drops;

  assign push_req = event_valid && (token_startstop_in != 2'b00);
  assign pop_req  = pop && out_valid;
  // A pop on a full FIFO frees the slot the simultaneous push lands in.
  assign do_write = push_req && (!full || pop_req);
  assign do_drop  = push_req && full && !pop_req;

  assign head                = mem[rd_ptr];
  assign processor_id_out    = out_valid ? head[ENTRY_W-1:2] : '0;
  assign token_startstop_out = out_valid ? head[1:0] : 2'b00;

  always_ff @(posedge clock_fast) begin
    if (!reset && !clear && do_write) begin
      mem[wr_ptr] <= {processor_id_in, token_startstop_in};
    end
  end

  always_ff @(posedge clock_fast) begin
    if (reset || clear) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      cnt    <= '0;
      ovf    <= 1'b0;
      drops  <= '0;
    end else begin
      if (do_write) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop_req)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({do_write, pop_req})
        2'b10:   cnt <= cnt + CNT_W'(1);
        2'b01:   cnt <= cnt - CNT_W'(1);
        default: cnt <= cnt;
      endcase
      if (do_drop) begin
        ovf <= 1'b1;
        if (drops != '1) drops <= drops + DROP_CNT_BITS'(1);
      end
    end
  end

endmodule

// File: tb/tb_tt_um_jleugeri_ttt_event_fifo.sv
// Self-checking bench for the event FIFO: directed scenarios plus randomized traffic
// compared against a queue-based reference model.
module tb_tt_um_jleugeri_ttt_event_fifo;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       event_valid = 1'b0;
  logic [3:0] processor_id_in = '0;
  logic [1:0] token_startstop_in = '0;
  logic       pop = 1'b0;
  logic       clear = 1'b0;
  logic       out_valid;
  logic [3:0] processor_id_out;
  logic [1:0] token_startstop_out;
  logic [3:0] count;
  logic       full;
  logic       overflow;
  logic [7:0] drop_count;

  int vectors = 0;
  int miscompares = 0;

  // Reference model state
  logic [5:0] mq[$];
  logic       m_ovf = 1'b0;
  int         m_drops = 0;

  tt_um_jleugeri_ttt_event_fifo #(.PROC_ID_BITS(4), .DEPTH(8), .DROP_CNT_BITS(8)) dut (
    .clock_fast(clk),
    .reset(reset),
    .event_valid(event_valid),
    .processor_id_in(processor_id_in),
    .token_startstop_in(token_startstop_in),
    .pop(pop),
    .clear(clear),
    .out_valid(out_valid),
    .processor_id_out(processor_id_out),
    .token_startstop_out(token_startstop_out),
    .count(count),
    .full(full),
    .overflow(overflow),
    .drop_count(drop_count)
  );

  always #5 clk = ~clk;

  // Applies one cycle of stimulus and advances the reference model; outputs are
  // valid for checking when this returns (#1 after the rising edge).
  task automatic cycle(input logic r, input logic c, input logic ev,
                       input logic [3:0] id, input logic [1:0] ss, input logic p);
    logic do_push;
    @(negedge clk);
    reset = r; clear = c; event_valid = ev;
    processor_id_in = id; token_startstop_in = ss; pop = p;
    @(posedge clk);
    if (r || c) begin
      mq.delete();
      m_ovf = 1'b0;
      m_drops = 0;
    end else begin
      do_push = ev && (ss != 2'b00);
      if (p && mq.size() > 0) void'(mq.pop_front());
      if (do_push) begin
        if (mq.size() < 8) mq.push_back({id, ss});
        else begin
          m_ovf = 1'b1;
          if (m_drops < 255) m_drops++;
        end
      end
    end
    #1;
    reset = 0; clear = 0; event_valid = 0; pop = 0;
  endtask

  task automatic test_reset();
    cycle(1, 0, 0, 4'h0, 2'b00, 0);
    vectors++;
    if (count !== 4'd0 || out_valid !== 1'b0 || full !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_status: count=%0d out_valid=%b full=%b, required 0/0/0", count, out_valid, full);
    end
    vectors++;
    if (processor_id_out !== 4'h0 || token_startstop_out !== 2'b00 || overflow !== 1'b0 || drop_count !== 8'd0) begin
      miscompares++;
      $display("FAIL reset_data: id=%h ss=%b ovf=%b drops=%0d, required 0", processor_id_out, token_startstop_out, overflow, drop_count);
    end
    for (int i = 0; i < 3; i++) begin
      cycle(0, 0, 0, 4'h0, 2'b00, 1);
      vectors++;
      if (count !== 4'd0 || out_valid !== 1'b0 || processor_id_out !== 4'h0 || drop_count !== 8'd0) begin
        miscompares++;
        $display("FAIL pop_empty: count=%0d out_valid=%b id=%h drops=%0d, required all 0", count, out_valid, processor_id_out, drop_count);
      end
    end
  endtask

  task automatic test_single();
    cycle(0, 0, 1, 4'h5, 2'b01, 0);
    vectors++;
    if (out_valid !== 1'b1 || processor_id_out !== 4'h5 || token_startstop_out !== 2'b01 || count !== 4'd1) begin
      miscompares++;
      $display("FAIL single_push: v=%b id=%h ss=%b count=%0d, required 1/5/01/1", out_valid, processor_id_out, token_startstop_out, count);
    end
    cycle(0, 0, 0, 4'h0, 2'b00, 1);
    vectors++;
    if (out_valid !== 1'b0 || processor_id_out !== 4'h0 || token_startstop_out !== 2'b00 || count !== 4'd0) begin
      miscompares++;
      $display("FAIL single_pop: v=%b id=%h ss=%b count=%0d, required 0/0/00/0", out_valid, processor_id_out, token_startstop_out, count);
    end
  endtask

  task automatic test_filter();
    cycle(0, 0, 1, 4'h3, 2'b00, 0);
    vectors++;
    if (count !== 4'd0 || drop_count !== 8'd0 || out_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL filter: count=%0d drops=%0d v=%b, required 0/0/0", count, drop_count, out_valid);
    end
  endtask

  task automatic test_fill_overflow();
    for (int i = 0; i < 10; i++) cycle(0, 0, 1, 4'(i), 2'b11, 0);
    vectors++;
    if (count !== 4'd8 || full !== 1'b1 || overflow !== 1'b1 || drop_count !== 8'd2) begin
      miscompares++;
      $display("FAIL fill: count=%0d full=%b ovf=%b drops=%0d, required 8/1/1/2", count, full, overflow, drop_count);
    end
    for (int i = 0; i < 8; i++) begin
      vectors++;
      if (out_valid !== 1'b1 || processor_id_out !== 4'(i) || token_startstop_out !== 2'b11) begin
        miscompares++;
        $display("FAIL drain_order[%0d]: v=%b id=%h ss=%b, required 1/%h/11", i, out_valid, processor_id_out, token_startstop_out, 4'(i));
      end
      cycle(0, 0, 0, 4'h0, 2'b00, 1);
    end
    vectors++;
    if (out_valid !== 1'b0 || count !== 4'd0 || overflow !== 1'b1 || drop_count !== 8'd2) begin
      miscompares++;
      $display("FAIL drained: v=%b count=%0d ovf=%b drops=%0d, required 0/0/1/2", out_valid, count, overflow, drop_count);
    end
    cycle(0, 0, 1, 4'hC, 2'b10, 0);
    vectors++;
    if (processor_id_out !== 4'hC || token_startstop_out !== 2'b10 || count !== 4'd1) begin
      miscompares++;
      $display("FAIL wrap: id=%h ss=%b count=%0d, required C/10/1", processor_id_out, token_startstop_out, count);
    end
    cycle(0, 0, 0, 4'h0, 2'b00, 1);
    vectors++;
    if (out_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL wrap_pop: v=%b, required 0", out_valid);
    end
  endtask

  task automatic test_pop_through();
    logic [3:0] exp_ids [8];
    for (int i = 0; i < 8; i++) cycle(0, 0, 1, 4'(i), 2'b01, 0);
    cycle(0, 0, 1, 4'hA, 2'b10, 1);
    vectors++;
    if (count !== 4'd8 || full !== 1'b1 || drop_count !== 8'd2) begin
      miscompares++;
      $display("FAIL pop_through: count=%0d full=%b drops=%0d, required 8/1/2", count, full, drop_count);
    end
    for (int i = 0; i < 7; i++) exp_ids[i] = 4'(i + 1);
    exp_ids[7] = 4'hA;
    for (int i = 0; i < 8; i++) begin
      vectors++;
      if (processor_id_out !== exp_ids[i]) begin
        miscompares++;
        $display("FAIL pop_through_order[%0d]: id=%h, required %h", i, processor_id_out, exp_ids[i]);
      end
      cycle(0, 0, 0, 4'h0, 2'b00, 1);
    end
  endtask

  task automatic test_clear();
    cycle(0, 1, 0, 4'h0, 2'b00, 0);
    for (int i = 0; i < 13; i++) cycle(0, 0, 1, 4'(i), 2'b01, 0);
    for (int i = 0; i < 5; i++) cycle(0, 0, 0, 4'h0, 2'b00, 1);
    vectors++;
    if (count !== 4'd3 || drop_count !== 8'd5) begin
      miscompares++;
      $display("FAIL clear_setup: count=%0d drops=%0d, required 3/5", count, drop_count);
    end
    cycle(0, 1, 1, 4'h7, 2'b11, 0);
    vectors++;
    if (count !== 4'd0 || overflow !== 1'b0 || drop_count !== 8'd0 || out_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL clear: count=%0d ovf=%b drops=%0d v=%b, required 0/0/0/0", count, overflow, drop_count, out_valid);
    end
  endtask

  task automatic test_saturate();
    for (int i = 0; i < 308; i++) cycle(0, 0, 1, 4'(i), 2'b01, 0);
    vectors++;
    if (drop_count !== 8'd255 || overflow !== 1'b1 || count !== 4'd8) begin
      miscompares++;
      $display("FAIL saturate: drops=%0d ovf=%b count=%0d, required 255/1/8", drop_count, overflow, count);
    end
    cycle(0, 1, 0, 4'h0, 2'b00, 0);
  endtask

  task automatic test_random();
    logic [5:0] h;
    logic r, c, ev, p;
    logic [3:0] id;
    logic [1:0] ss;
    for (int n = 0; n < 600; n++) begin
      r  = ($urandom_range(0, 199) == 0);
      c  = ($urandom_range(0, 79) == 0);
      ev = ($urandom_range(0, 99) < 60);
      id = 4'($urandom_range(0, 15));
      ss = 2'($urandom_range(0, 3));
      p  = ($urandom_range(0, 99) < ((n / 100) % 2 == 0 ? 30 : 70));
      cycle(r, c, ev, id, ss, p);
      h = (mq.size() > 0) ? mq[0] : 6'h00;
      vectors++;
      if (count !== 4'(mq.size()) || out_valid !== (mq.size() > 0) || full !== (mq.size() == 8) ||
          overflow !== m_ovf || drop_count !== 8'(m_drops) ||
          processor_id_out !== h[5:2] || token_startstop_out !== h[1:0]) begin
        miscompares++;
        $display("FAIL random[%0d]: count=%0d v=%b full=%b ovf=%b drops=%0d id=%h ss=%b, required %0d/%b/%b/%b/%0d/%h/%b",
                 n, count, out_valid, full, overflow, drop_count, processor_id_out, token_startstop_out,
                 mq.size(), mq.size() > 0, mq.size() == 8, m_ovf, m_drops, h[5:2], h[1:0]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_filter();
    test_fill_overflow();
    test_pop_through();
    test_clear();
    test_saturate();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
